// File: rtl/led_pkg.sv
// Shared types and default sizing for the LED scan scheduler.
package led_pkg;

    localparam int unsigned N_SL_DEF      = 32;
    localparam int unsigned N_COL_DEF     = 16;
    localparam int unsigned GCNT_W_DEF    = 16;
    localparam int unsigned PWM_LEN_DEF   = 1024;
    localparam int unsigned BLANK_LEN_DEF = 4;

    localparam int unsigned SL_W  = $clog2(N_SL_DEF);
    localparam int unsigned COL_W = $clog2(N_COL_DEF);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PWM,
        BLANK
    } state_e;

endpackage

// File: rtl/led_line_loader.sv
// Column walker for one scan line: 2 cycles per column, col_ld on the second.
module led_line_loader import led_pkg::*; #(
    parameter int unsigned N_COL = N_COL_DEF
) (
    input  logic                     GCK,
    input  logic                     rst,
    input  logic                     start,
    output logic [$clog2(N_COL)-1:0] col_idx,
    output logic                     col_ld,
    output logic                     done_c
);

    localparam int unsigned IDX_W = $clog2(N_COL);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COL - 1);

    logic busy;

    // High on the shadow write of the last column.
    assign done_c = busy && col_ld && (col_idx == LAST_IDX);

    always_ff @(posedge GCK or negedge rst) begin
        if (!rst) begin
            busy    <= 1'b0;
            col_ld  <= 1'b0;
            col_idx <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            col_ld  <= 1'b0;
            col_idx <= '0;
        end else if (busy) begin
            if (!col_ld) begin
                col_ld <= 1'b1;
            end else if (done_c) begin
                busy    <= 1'b0;
                col_ld  <= 1'b0;
                col_idx <= '0;
            end else begin
                col_ld  <= 1'b0;
                col_idx <= col_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_scan_scheduler.sv
// GCK-domain scan sequencer: line pre-load, Vsync/PWM gray count, pixel update and read-bank handshake.
// Optional LED_DITHER_EN: dith_phase flips at every frame start.
module led_scan_scheduler import led_pkg::*; #(
    parameter int unsigned N_SL      = N_SL_DEF,
    parameter int unsigned N_COL     = N_COL_DEF,
    parameter int unsigned GCNT_W    = GCNT_W_DEF,
    parameter int unsigned PWM_LEN   = PWM_LEN_DEF,
    parameter int unsigned BLANK_LEN = BLANK_LEN_DEF
) (
    input  logic                                   GCK,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic                                   frm_rdy,
    output logic                                   frm_ack,
    output logic                                   rd_bank,
    output logic [$clog2(N_SL)+$clog2(N_COL)-1:0]  rd_addr,
    output logic                                   col_ld,
    output logic [$clog2(N_COL)-1:0]               col_idx,
    output logic                                   pix_upd,
    output logic                                   Vsync,
    output logic [GCNT_W-1:0]                      gcnt,
    output logic [$clog2(N_SL)-1:0]                scan_line,
    output logic                                   dith_phase
);

    localparam int unsigned LINE_W = $clog2(N_SL);
    localparam int unsigned BLK_W  = $clog2(BLANK_LEN + 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(N_SL - 1);
    localparam logic [GCNT_W-1:0] LAST_GCNT = GCNT_W'(PWM_LEN - 1);
    localparam logic [BLK_W-1:0]  LAST_BLK  = BLK_W'(BLANK_LEN - 1);

    if (PWM_LEN < 2 * N_COL || BLANK_LEN < 1 ||
        longint'(PWM_LEN) > (longint'(1) << GCNT_W)) begin : g_param_err
        $error("led_scan_scheduler: need 2*N_COL <= PWM_LEN <= 2**GCNT_W and BLANK_LEN >= 1");
    end

    state_e            state, state_n;
    logic [LINE_W-1:0] ld_line, ld_line_n, scan_line_n, ld_line_inc;
    logic [GCNT_W-1:0] gcnt_n;
    logic [BLK_W-1:0]  blk_cnt, blk_cnt_n;
    logic              vsync_n, pix_upd_n, frm_ack_n, rd_bank_n;
    logic              ld_start_c, ld_done_c;

    led_line_loader #(
        .N_COL (N_COL)
    ) u_loader (
        .GCK     (GCK),
        .rst     (rst),
        .start   (ld_start_c),
        .col_idx (col_idx),
        .col_ld  (col_ld),
        .done_c  (ld_done_c)
    );

    assign rd_addr     = {ld_line, col_idx};
    assign ld_line_inc = (ld_line == LAST_LINE) ? '0 : ld_line + LINE_W'(1);

    always_comb begin
        state_n     = state;
        ld_line_n   = ld_line;
        scan_line_n = scan_line;
        gcnt_n      = '0;
        blk_cnt_n   = '0;
        vsync_n     = 1'b0;
        pix_upd_n   = 1'b0;
        frm_ack_n   = 1'b0;
        rd_bank_n   = rd_bank;
        ld_start_c  = 1'b0;
        unique case (state)
            IDLE: begin
                if (en && frm_rdy) begin
                    state_n    = LOAD;
                    frm_ack_n  = 1'b1;
                    rd_bank_n  = ~rd_bank;
                    ld_line_n  = '0;
                    ld_start_c = 1'b1;
                end
            end
            LOAD: begin
                if (ld_done_c) begin
                    state_n     = PWM;
                    vsync_n     = 1'b1;
                    pix_upd_n   = 1'b1;
                    scan_line_n = ld_line;
                    ld_line_n   = ld_line_inc;
                    ld_start_c  = 1'b1;
                end
            end
            PWM: begin
                vsync_n = 1'b1;
                gcnt_n  = gcnt + GCNT_W'(1);
                // Bank swap only while the last line is shown, before line 0 is fetched.
                if (gcnt == '0 && scan_line == LAST_LINE && frm_rdy) begin
                    frm_ack_n = 1'b1;
                    rd_bank_n = ~rd_bank;
                end
                if (gcnt == LAST_GCNT) begin
                    state_n = BLANK;
                    vsync_n = 1'b0;
                    gcnt_n  = '0;
                end
            end
            BLANK: begin
                blk_cnt_n = blk_cnt + BLK_W'(1);
                if (blk_cnt == LAST_BLK) begin
                    blk_cnt_n = '0;
                    if (scan_line == LAST_LINE && !en) begin
                        state_n     = IDLE;
                        scan_line_n = '0;
                    end else begin
                        state_n     = PWM;
                        vsync_n     = 1'b1;
                        pix_upd_n   = 1'b1;
                        scan_line_n = ld_line;
                        ld_line_n   = ld_line_inc;
                        ld_start_c  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge GCK or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ld_line   <= '0;
            scan_line <= '0;
            gcnt      <= '0;
            blk_cnt   <= '0;
            Vsync     <= 1'b0;
            pix_upd   <= 1'b0;
            frm_ack   <= 1'b0;
            rd_bank   <= 1'b0;
        end else begin
            state     <= state_n;
            ld_line   <= ld_line_n;
            scan_line <= scan_line_n;
            gcnt      <= gcnt_n;
            blk_cnt   <= blk_cnt_n;
            Vsync     <= vsync_n;
            pix_upd   <= pix_upd_n;
            frm_ack   <= frm_ack_n;
            rd_bank   <= rd_bank_n;
        end
    end

`ifdef LED_DITHER_EN
    // A pixel update whose new scan line is 0 marks a frame start.
    logic frame_start_c;
    assign frame_start_c = pix_upd_n && (ld_line == '0);

    always_ff @(posedge GCK or negedge rst) begin
        if (!rst) begin
            dith_phase <= 1'b0;
        end else if (frame_start_c) begin
            dith_phase <= ~dith_phase;
        end
    end
`else
    assign dith_phase = 1'b0;
`endif

endmodule
